// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage feeding the IF/ID register.
// Owns the PC, reads a 1-cycle-latency instruction memory and buffers returned
// words in a small circular queue. A read is only issued when a queue slot is
// guaranteed for its return, so the queue can never overflow.
// Optional build macro IF_FETCH_PERF_CNT_EN adds saturating fetch/bubble counters.
module if_fetch_unit #(
    parameter int          ADDR_BIT = 10,
    parameter int unsigned RESET_PC = 0,
    parameter int          FQ_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                redir_en,
    input  logic [ADDR_BIT-1:0] redir_pc,
    input  logic                halt,
    output logic [ADDR_BIT-1:0] im_addr,
    output logic                im_rd_en,
    input  logic [31:0]         im_data,
    output logic [31:0]         inst,
    output logic [ADDR_BIT-1:0] pc_4,
    output logic                inst_valid
`ifdef IF_FETCH_PERF_CNT_EN
    ,
    output logic [31:0]         perf_fetch_cnt,
    output logic [31:0]         perf_bubble_cnt
`endif
);

    localparam int PTR_W = $clog2(FQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]         q_inst [FQ_DEPTH];
    logic [ADDR_BIT-1:0] q_pc4  [FQ_DEPTH];
    logic [PTR_W-1:0]    head;
    logic [PTR_W-1:0]    tail;
    logic [CNT_W-1:0]    count;
    logic [ADDR_BIT-1:0] pc;
    logic [ADDR_BIT-1:0] issued_pc;
    logic                inflight;
    logic                pop;
    logic                issue;
    logic [CNT_W:0]      occ;

    // Credit check and head presentation; reset forces every output low.
    always_comb begin
        inst_valid = (count != '0);
        pop        = en && inst_valid;
        occ        = {1'b0, count} + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);
        issue      = !rst && !halt && !redir_en && (occ < (CNT_W+1)'(FQ_DEPTH));
        im_rd_en   = issue;
        im_addr    = issue ? pc : '0;
        inst       = inst_valid ? q_inst[head] : 32'h0;
        pc_4       = inst_valid ? q_pc4[head] : '0;
    end

    // PC, pointers, occupancy and the outstanding-read flag; redirect flushes everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= ADDR_BIT'(RESET_PC);
            issued_pc <= '0;
            inflight  <= 1'b0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
        end else if (redir_en) begin
            pc       <= redir_pc;
            inflight <= 1'b0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            if (inflight) begin
                tail <= tail + PTR_W'(1);
            end
            count    <= count + CNT_W'(inflight) - CNT_W'(pop);
            inflight <= issue;
            if (issue) begin
                issued_pc <= pc;
                pc        <= pc + ADDR_BIT'(1);
            end
        end
    end

    // Queue storage; a returning word is dropped when a redirect lands on the same edge.
    always_ff @(posedge clk) begin
        if (inflight && !redir_en) begin
            q_inst[tail] <= im_data;
            q_pc4[tail]  <= issued_pc + ADDR_BIT'(1);
        end
    end

`ifdef IF_FETCH_PERF_CNT_EN
    // Saturating counters: delivered instructions and cycles the consumer found nothing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_cnt  <= '0;
            perf_bubble_cnt <= '0;
        end else begin
            if (pop && !redir_en && (perf_fetch_cnt != 32'hFFFF_FFFF)) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (en && !inst_valid && !halt && (perf_bubble_cnt != 32'hFFFF_FFFF)) begin
                perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
